seg_msg_scheduler: RTL and testbench

SEG_MSG_SCHEDULER -- requirements
Module: seg_msg_scheduler

---
 rtl/seg_msg_scheduler_pkg.sv | 26 ++
 rtl/seg_msg_scheduler_seg7_decode.sv | 19 +
 rtl/seg_msg_scheduler.sv | 161 ++++++++++++++++
 tb/tb_seg_msg_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_msg_scheduler_pkg.sv
// ============================================================================
// Module      : seg_msg_scheduler_pkg
// Description : FSM state encoding and hex glyph table for the message player.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_msg_scheduler_pkg;

  typedef logic [1:0] state_t;

  localparam state_t C_ST_IDLE = 2'd0;
  localparam state_t C_ST_SHOW = 2'd1;
  localparam state_t C_ST_GAP  = 2'd2;

  localparam logic [6:0] C_BLANK = 7'h00;

  // Entry n holds the glyph for hex digit n; segment a is bit 0.
  localparam logic [15:0][6:0] C_GLYPH_ROM = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

`default_nettype wire

// File: rtl/seg_msg_scheduler_seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : Combinational hex digit to 7-segment glyph decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
  import seg_msg_scheduler_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segments
);

  assign segments = C_GLYPH_ROM[hex];

endmodule

`default_nettype wire

// File: rtl/seg_msg_scheduler.sv
// ============================================================================
// Module      : seg_msg_scheduler
// Description : Plays an 8-slot hex message on a 7-segment digit with
//               per-character dwell, optional blank gap and looping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_msg_scheduler
  import seg_msg_scheduler_pkg::*;
#(
  parameter int DWELL_CYCLES = 10000000,
  parameter int GAP_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       start,
  input  logic [2:0] len_m1,
  input  logic       loop,
  input  logic       stop,
  output logic [6:0] segments,
  output logic       busy,
  output logic       done,
  output logic [2:0] idx
);

  localparam int C_CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_DWELL_LOAD = C_CNT_W'(DWELL_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LOAD   = C_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               r_state;
  logic [2:0]           r_idx;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_len;
  logic                 r_loop;
  logic                 r_done;
  logic [3:0]           r_buf [8];

  state_t               w_state_nxt;
  logic [2:0]           w_idx_nxt;
  logic [2:0]           w_idx_inc;
  logic [C_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_finish;
  logic                 w_capture;
  logic [3:0]           w_cur_hex;
  logic [6:0]           w_glyph;

  assign w_idx_inc = (r_idx == r_len) ? 3'd0 : r_idx + 3'd1;
  assign w_cur_hex = r_buf[r_idx];

  seg7_decode u_decode (
    .hex      (w_cur_hex),
    .segments (w_glyph)
  );

  // The message buffer is only writable while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_buf[i] <= '0;
    end else if (ena && wr_en && (r_state == C_ST_IDLE)) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_done  <= 1'b0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_finish;
      if (w_capture) begin
        r_len  <= len_m1;
        r_loop <= loop;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  // The counter reloads on every state entry and expires when it reads zero.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    w_finish    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      C_ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = C_ST_SHOW;
          w_idx_nxt   = '0;
          w_cnt_nxt   = C_DWELL_LOAD;
          w_capture   = 1'b1;
        end
      end
      C_ST_SHOW: begin
        if (stop) begin
          w_state_nxt = C_ST_IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          if ((r_idx != r_len) || r_loop) begin
            if (GAP_CYCLES > 0) begin
              w_state_nxt = C_ST_GAP;
              w_cnt_nxt   = C_GAP_LOAD;
            end else begin
              w_state_nxt = C_ST_SHOW;
              w_idx_nxt   = w_idx_inc;
              w_cnt_nxt   = C_DWELL_LOAD;
            end
          end else begin
            w_state_nxt = C_ST_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_finish    = 1'b1;
          end
        end
      end
      C_ST_GAP: begin
        if (stop) begin
          w_state_nxt = C_ST_IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = C_ST_SHOW;
          w_idx_nxt   = w_idx_inc;
          w_cnt_nxt   = C_DWELL_LOAD;
        end
      end
      default: begin
        w_state_nxt = C_ST_IDLE;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    segments = C_BLANK;
    busy     = (r_state != C_ST_IDLE);
    if (r_state == C_ST_SHOW) segments = w_glyph;
  end

  assign done = r_done;
  assign idx  = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_seg_msg_scheduler.sv
// ============================================================================
// Module      : tb_seg_msg_scheduler
// Description : Scoreboard bench for seg_msg_scheduler against a trace model.
// Revision    : 1.1 - added direct reset and wait-timeout checks
// ============================================================================
`default_nettype none

module tb_seg_msg_scheduler;

    localparam int D = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       start = 1'b0;
    logic [2:0] len_m1 = '0;
    logic       loop = 1'b0;
    logic       stop = 1'b0;
    logic [6:0] segments;
    logic       busy;
    logic       done;
    logic [2:0] idx;
    logic       probe = 1'b0;

    seg_msg_scheduler #(.DWELL_CYCLES(D), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .len_m1(len_m1), .loop(loop), .stop(stop),
        .segments(segments), .busy(busy), .done(done), .idx(idx)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [6:0] seg; logic [2:0] idx; } frame_t;
    typedef struct packed { logic [6:0] seg; logic busy; logic done; logic [2:0] idx; } exp_t;

    // Reference model: a message is expanded into its full frame list up front.
    frame_t     plan[$];
    exp_t       exp_q[$];
    exp_t       cur = '0;
    exp_t       mon_e;
    logic [3:0] m_buf [8];
    logic [2:0] m_len = '0;
    logic       m_loop = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic void build_plan();
        frame_t f;
        for (int i = 0; i <= int'(m_len); i++) begin
            f.seg = glyph(m_buf[i]);
            f.idx = 3'(i);
            repeat (D) plan.push_back(f);
            if (i < int'(m_len) || m_loop) begin
                f.seg = 7'h00;
                repeat (G) plan.push_back(f);
            end
        end
    endfunction

    function automatic void model_reset();
        plan.delete();
        cur = '0;
        m_len = '0;
        m_loop = 1'b0;
        for (int i = 0; i < 8; i++) m_buf[i] = '0;
    endfunction

    function automatic void model_step(input logic e, input logic we, input logic [2:0] wa,
                                       input logic [3:0] wd, input logic st, input logic [2:0] lm,
                                       input logic lp, input logic sp);
        frame_t f;
        exp_t   n;
        n = '0;
        if (!e) begin
            n = cur;
            n.done = 1'b0;
        end else if (!cur.busy) begin
            if (we) m_buf[wa] = wd;
            if (st && !sp) begin
                m_len = lm;
                m_loop = lp;
                plan.delete();
                build_plan();
                f = plan.pop_front();
                n = {f.seg, 1'b1, 1'b0, f.idx};
            end
        end else if (!sp) begin
            if (plan.size() == 0 && m_loop) build_plan();
            if (plan.size() > 0) begin
                f = plan.pop_front();
                n = {f.seg, 1'b1, 1'b0, f.idx};
            end else begin
                n.done = 1'b1;
            end
        end
        cur = n;
    endfunction

    always @(negedge clk or posedge probe) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (segments !== mon_e.seg || busy !== mon_e.busy || done !== mon_e.done ||
                (mon_e.busy && idx !== mon_e.idx)) begin
                miscompares++;
                $display("FAIL out_check t=%0t got seg=%h busy=%b done=%b idx=%0d expected seg=%h busy=%b done=%b idx=%0d",
                         $time, segments, busy, done, idx, mon_e.seg, mon_e.busy, mon_e.done, mon_e.idx);
            end
        end
    end

    task automatic check_idle(input string tag);
        if (segments !== 7'h00 || busy !== 1'b0 || done !== 1'b0 || idx !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_check %s t=%0t got seg=%h busy=%b done=%b idx=%0d expected all zero",
                     tag, $time, segments, busy, done, idx);
        end
    endtask

    task automatic step(input logic e, input logic we, input logic [2:0] wa, input logic [3:0] wd,
                        input logic st, input logic [2:0] lm, input logic lp, input logic sp);
        ena = e; wr_en = we; wr_addr = wa; wr_data = wd;
        start = st; len_m1 = lm; loop = lp; stop = sp;
        model_step(e, we, wa, wd, st, lm, lp, sp);
        @(posedge clk);
        exp_q.push_back(cur);
        #1;
    endtask

    task automatic nop(input int n);
        repeat (n) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic go(input logic [2:0] lm, input logic lp);
        step(1'b1, 1'b0, 3'd0, 4'd0, 1'b1, lm, lp, 1'b0);
    endtask

    task automatic until_show();
        for (int k = 0; k < 50 && !(cur.busy && cur.seg != 7'h00); k++) nop(1);
        if (!(cur.busy && cur.seg != 7'h00)) begin
            miscompares++;
            $display("FAIL wait_timeout until_show t=%0t expired without reaching SHOW", $time);
        end
    endtask

    task automatic until_gap();
        for (int k = 0; k < 50 && !(cur.busy && cur.seg == 7'h00); k++) nop(1);
        if (!(cur.busy && cur.seg == 7'h00)) begin
            miscompares++;
            $display("FAIL wait_timeout until_gap t=%0t expired without reaching GAP", $time);
        end
    endtask

    // Reset is asserted between clock edges and checked before any edge arrives.
    task automatic async_reset_check();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 exp_q.push_back('0);
        check_idle("mid_gap");
        probe = 1'b1;
        #1 probe = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e, we, st, lp, sp;
        logic [2:0] wa, lm;
        logic [3:0] wd;
        model_reset();
        #1 rst_n = 1'b0;
        #2 exp_q.push_back('0);
        check_idle("power_on");
        probe = 1'b1;
        #1 probe = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        nop(2);
        wr(3'd0, 4'd1); wr(3'd1, 4'd2); wr(3'd2, 4'd3);
        go(3'd2, 1'b0); nop(22);
        go(3'd2, 1'b1); nop(10);
        wr(3'd0, 4'd8); nop(12);
        until_show(); nop(1);
        step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        nop(3);
        go(3'd2, 1'b0); nop(20);
        go(3'd2, 1'b0); nop(1);
        repeat (5) step(1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        nop(20);
        go(3'd2, 1'b0); nop(4); until_gap();
        async_reset_check();
        wr(3'd0, 4'd1);
        go(3'd0, 1'b0); nop(8);
        wr(3'd0, 4'hA); wr(3'd1, 4'hF); wr(3'd2, 4'h8); wr(3'd3, 4'h0);
        go(3'd3, 1'b0); nop(26);
        for (int k = 0; k < 600; k++) begin
            e  = ($urandom_range(0, 9) != 0);
            we = ($urandom_range(0, 2) == 0);
            wa = 3'($urandom_range(0, 7));
            wd = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 5) == 0);
            lm = 3'($urandom_range(0, 7));
            lp = ($urandom_range(0, 1) == 1);
            sp = ($urandom_range(0, 40) == 0);
            step(e, we, wa, wd, st, lm, lp, sp);
        end
        nop(3);
        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares != 0)
            $display("TEST FAILED");
        else
            $display("TEST PASSED");
        $finish;
    end

endmodule

`default_nettype wire
